// File: rtl/store_buffer_fwd_if.sv
// Signal bundle for store_buffer_fwd: enqueue/completion, commit, forwarding query and dcache store port.
// The core side drives through master; the store buffer attaches through slave.
interface store_buffer_fwd_if #(
   parameter int COMMIT_W = 2,
   parameter int ROB_W    = 5,
   parameter int ADDR_W   = 30
);
   logic                flush_i;
   logic                enq_en_i;
   logic [ADDR_W-1:0]   enq_addr_i;
   logic [31:0]         enq_data_i;
   logic [3:0]          enq_bm_i;
   logic                enq_io_i;
   logic [ROB_W-1:0]    enq_rob_i;
   logic                full_o;
   logic                cmp_valid_o;
   logic [ROB_W-1:0]    cmp_rob_o;
   logic [COMMIT_W-1:0] commit_i;
   logic [ADDR_W-1:0]   q_addr_i;
   logic [3:0]          q_bm_i;
   logic [31:0]         fwd_data_o;
   logic [3:0]          fwd_bm_o;
   logic                fwd_hit_o;
   logic                fwd_ok_o;
   logic                st_valid_o;
   logic [ADDR_W-1:0]   st_addr_o;
   logic [31:0]         st_data_o;
   logic [3:0]          st_bm_o;
   logic                st_done_i;
   logic                empty_o;

   modport master (
      output flush_i, enq_en_i, enq_addr_i, enq_data_i, enq_bm_i, enq_io_i, enq_rob_i,
             commit_i, q_addr_i, q_bm_i, st_done_i,
      input  full_o, cmp_valid_o, cmp_rob_o, fwd_data_o, fwd_bm_o, fwd_hit_o, fwd_ok_o,
             st_valid_o, st_addr_o, st_data_o, st_bm_o, empty_o
   );

   modport slave (
      input  flush_i, enq_en_i, enq_addr_i, enq_data_i, enq_bm_i, enq_io_i, enq_rob_i,
             commit_i, q_addr_i, q_bm_i, st_done_i,
      output full_o, cmp_valid_o, cmp_rob_o, fwd_data_o, fwd_bm_o, fwd_hit_o, fwd_ok_o,
             st_valid_o, st_addr_o, st_data_o, st_bm_o, empty_o
   );
endinterface

// File: rtl/store_buffer_fwd.sv
// Speculative store buffer: in-order enqueue, multi-store commit, in-order drain to dcache,
// and per-byte youngest-wins store-to-load forwarding over all held entries.
module store_buffer_fwd #(
   parameter int DEPTH    = 8,
   parameter int COMMIT_W = 2,
   parameter int ROB_W    = 5,
   parameter int ADDR_W   = 30
) (
   input  logic              cpu_clk_i,
   input  logic              cpu_rst_ni,
   store_buffer_fwd_if.slave sb
);
   localparam int PW = $clog2(DEPTH);

   typedef logic [PW:0] ptr_t;
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
      logic [3:0]        bm;
      logic              io;
   } entry_t;

   entry_t           mem_q [DEPTH];
   ptr_t             head_q, head_d, cptr_q, cptr_d, tail_q, tail_d;
   ptr_t             used, uncommitted, cmt_cnt, slot;
   logic             full, enq_acc, pop;
   logic             cmp_pend_q;
   logic [ROB_W-1:0] cmp_rob_q;
   entry_t           head_e, fwd_e;
   logic [31:0]      fwd_data;
   logic [3:0]       fwd_bm, fwd_io;

   assign used        = tail_q - head_q;
   assign uncommitted = tail_q - cptr_q;
   assign full        = (used == ptr_t'(DEPTH));
   assign enq_acc     = sb.enq_en_i & ~full & ~sb.flush_i;
   assign pop         = sb.st_done_i & (head_q != cptr_q);

   always_comb begin
      // NOTE: every always_comb target gets a default first, so no path can infer a latch.
      cmt_cnt = '0;
      // Each pulse counts only while uncommitted entries remain, which saturates cptr at tail.
      for (int i = 0; i < COMMIT_W; i++) begin
         if (sb.commit_i[i] && (cmt_cnt != uncommitted)) cmt_cnt = cmt_cnt + ptr_t'(1);
      end
      cptr_d = cptr_q + cmt_cnt;
      head_d = pop ? head_q + ptr_t'(1) : head_q;
      tail_d = tail_q;
      if (sb.flush_i)   tail_d = cptr_d;
      else if (enq_acc) tail_d = tail_q + ptr_t'(1);
   end

   always_ff @(posedge cpu_clk_i or negedge cpu_rst_ni) begin
      if (!cpu_rst_ni) begin
         head_q     <= '0;
         cptr_q     <= '0;
         tail_q     <= '0;
         cmp_pend_q <= 1'b0;
         cmp_rob_q  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
         head_q     <= head_d;
         cptr_q     <= cptr_d;
         tail_q     <= tail_d;
         cmp_pend_q <= enq_acc;
         if (enq_acc) cmp_rob_q <= sb.enq_rob_i;
      end
   end

   // NOTE: entry storage is not reset; an entry is valid only while it lies between head and tail.
   always_ff @(posedge cpu_clk_i) begin
      if (enq_acc) begin
         mem_q[tail_q[PW-1:0]] <= '{addr: sb.enq_addr_i, data: sb.enq_data_i,
                                   bm: sb.enq_bm_i, io: sb.enq_io_i};
      end
   end

   // Walk oldest to youngest so a younger match overwrites an older one byte by byte.
   always_comb begin
      fwd_data = '0;
      fwd_bm   = '0;
      fwd_io   = '0;
      slot     = '0;
      fwd_e    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         slot  = head_q + ptr_t'(i);
         fwd_e = mem_q[slot[PW-1:0]];
         if ((ptr_t'(i) < used) && (fwd_e.addr == sb.q_addr_i)) begin
            for (int b = 0; b < 4; b++) begin
               if (fwd_e.bm[b] && sb.q_bm_i[b]) begin
                  fwd_data[8*b +: 8] = fwd_e.data[8*b +: 8];
                  fwd_bm[b]          = 1'b1;
                  fwd_io[b]          = fwd_e.io;
               end
            end
         end
      end
   end

   assign head_e         = mem_q[head_q[PW-1:0]];
   assign sb.full_o      = full;
   assign sb.empty_o     = (tail_q == head_q);
   assign sb.cmp_valid_o = cmp_pend_q & ~sb.flush_i;
   assign sb.cmp_rob_o   = cmp_rob_q;
   assign sb.st_valid_o  = (head_q != cptr_q);
   assign sb.st_addr_o   = head_e.addr;
   assign sb.st_data_o   = head_e.data;
   assign sb.st_bm_o     = head_e.bm;
   assign sb.fwd_data_o  = fwd_data;
   assign sb.fwd_bm_o    = fwd_bm;
   assign sb.fwd_hit_o   = |fwd_bm;
   assign sb.fwd_ok_o    = (fwd_bm == sb.q_bm_i) & ~|fwd_io & (|sb.q_bm_i);
endmodule

// File: tb/tb_store_buffer_fwd.sv
// Bench for store_buffer_fwd: directed scenarios plus random traffic against a queue-based model.
module tb_store_buffer_fwd;
   localparam int DEPTH = 8;

   typedef struct {
      logic [29:0] addr;
      logic [31:0] data;
      logic [3:0]  bm;
      logic        io;
   } st_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;

   // Reference model: program-order list of held stores, the first ncom of them committed.
   st_t         mq[$];
   int          ncom = 0;
   bit          m_pend = 0;
   logic [4:0]  m_rob = '0;

   store_buffer_fwd_if #(.COMMIT_W(2), .ROB_W(5), .ADDR_W(30)) sb ();

   store_buffer_fwd #(.DEPTH(DEPTH), .COMMIT_W(2), .ROB_W(5), .ADDR_W(30)) dut (
      .cpu_clk_i (clk),
      .cpu_rst_ni(rst_n),
      .sb        (sb)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive_idle();
      sb.flush_i = 0; sb.enq_en_i = 0; sb.enq_addr_i = '0; sb.enq_data_i = '0;
      sb.enq_bm_i = '0; sb.enq_io_i = 0; sb.enq_rob_i = '0; sb.commit_i = '0;
      sb.q_addr_i = '0; sb.q_bm_i = '0; sb.st_done_i = 0;
   endtask

   task automatic drive_enq(input logic [29:0] a, input logic [31:0] d, input logic [3:0] bm,
                            input logic io, input logic [4:0] rob);
      sb.enq_en_i = 1; sb.enq_addr_i = a; sb.enq_data_i = d;
      sb.enq_bm_i = bm; sb.enq_io_i = io; sb.enq_rob_i = rob;
   endtask

   task automatic m_reset();
      mq.delete();
      ncom = 0;
      m_pend = 0;
      m_rob = '0;
   endtask

   // Advance one clock, applying the architectural rules to the model with the inputs held at the edge.
   task automatic tick();
      st_t e;
      bit  acc, popd;
      int  adv;
      acc  = sb.enq_en_i && (mq.size() < DEPTH) && !sb.flush_i;
      adv  = $countones(sb.commit_i);
      if (adv > mq.size() - ncom) adv = mq.size() - ncom;
      popd = sb.st_done_i && (ncom > 0);
      e.addr = sb.enq_addr_i; e.data = sb.enq_data_i; e.bm = sb.enq_bm_i; e.io = sb.enq_io_i;
      if (acc) m_rob = sb.enq_rob_i;
      m_pend = acc;
      @(posedge clk);
      ncom += adv;
      if (popd) begin
         void'(mq.pop_front());
         ncom--;
      end
      if (sb.flush_i) while (mq.size() > ncom) void'(mq.pop_back());
      if (acc) mq.push_back(e);
      #1;
   endtask

   // Per byte, search from youngest store to oldest for a covering one.
   function automatic void m_fwd(input logic [29:0] a, input logic [3:0] qb,
                                 output logic [31:0] d, output logic [3:0] bmo, output logic ok);
      bit io_any = 0;
      d = '0;
      bmo = '0;
      for (int b = 0; b < 4; b++) begin
         if (qb[b]) begin
            for (int k = mq.size() - 1; k >= 0; k--) begin
               if (mq[k].addr == a && mq[k].bm[b]) begin
                  d[8*b +: 8] = mq[k].data[8*b +: 8];
                  bmo[b] = 1'b1;
                  if (mq[k].io) io_any = 1;
                  break;
               end
            end
         end
      end
      ok = (bmo == qb) && !io_any && (qb != 4'b0);
   endfunction

   task automatic drain_all();
      int n = 0;
      drive_idle();
      sb.commit_i = 2'b11;
      sb.st_done_i = 1;
      while (mq.size() != 0 && n < 64) begin
         tick();
         n++;
      end
      drive_idle();
      #2;
      checks++;
      if (sb.empty_o !== 1'b1) begin
         failures++;
         $display("FAIL drain_all_empty: empty_o=%b required 1 after %0d cycles", sb.empty_o, n);
      end
   endtask

   task automatic test_reset();
      drive_idle();
      rst_n = 0;
      m_reset();
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if ({sb.full_o, sb.empty_o, sb.cmp_valid_o, sb.st_valid_o} !== 4'b0100) begin
         failures++;
         $display("FAIL reset_flags: full/empty/cmp/st=%b required 0100",
                  {sb.full_o, sb.empty_o, sb.cmp_valid_o, sb.st_valid_o});
      end
      checks++;
      if (sb.cmp_rob_o !== 5'd0) begin
         failures++;
         $display("FAIL reset_cmp_rob: got %0d required 0", sb.cmp_rob_o);
      end
      rst_n = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_fill();
      int cmp_seen = 0;
      for (int i = 0; i < 8; i++) begin
         drive_enq(30'h10 + 30'(i), $urandom, 4'hf, 0, 5'(i));
         #2;
         checks++;
         if (sb.full_o !== 1'b0) begin
            failures++;
            $display("FAIL fill_full_early: enq %0d full_o=%b required 0", i, sb.full_o);
         end
         checks++;
         if (sb.cmp_valid_o !== (i > 0) || (i > 0 && sb.cmp_rob_o !== 5'(i - 1))) begin
            failures++;
            $display("FAIL fill_cmp: enq %0d cmp_valid=%b rob=%0d required %b rob=%0d",
                     i, sb.cmp_valid_o, sb.cmp_rob_o, i > 0, i - 1);
         end
         if (sb.cmp_valid_o === 1'b1) cmp_seen++;
         tick();
      end
      drive_enq(30'h18, 32'hdead_beef, 4'hf, 0, 5'd8);
      #2;
      checks++;
      if (sb.full_o !== 1'b1) begin
         failures++;
         $display("FAIL fill_full: full_o=%b required 1", sb.full_o);
      end
      checks++;
      if (sb.cmp_valid_o !== 1'b1 || sb.cmp_rob_o !== 5'd7) begin
         failures++;
         $display("FAIL fill_cmp_last: cmp_valid=%b rob=%0d required 1 rob=7", sb.cmp_valid_o, sb.cmp_rob_o);
      end
      if (sb.cmp_valid_o === 1'b1) cmp_seen++;
      tick();
      drive_idle();
      #2;
      checks++;
      if (sb.cmp_valid_o !== 1'b0 || sb.full_o !== 1'b1) begin
         failures++;
         $display("FAIL fill_reject: cmp_valid=%b full=%b required 0 1", sb.cmp_valid_o, sb.full_o);
      end
      checks++;
      if (cmp_seen != 8) begin
         failures++;
         $display("FAIL fill_cmp_count: got %0d pulses required 8", cmp_seen);
      end
   endtask

   task automatic test_drain();
      logic [29:0] exp_addr [2];
      exp_addr[0] = 30'h10;
      exp_addr[1] = 30'h11;
      sb.commit_i = 2'b11;
      sb.st_done_i = 1;
      #2;
      checks++;
      if (sb.st_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL drain_pre_commit: st_valid=%b required 0", sb.st_valid_o);
      end
      tick();
      sb.commit_i = '0;
      for (int k = 0; k < 2; k++) begin
         #2;
         checks++;
         if (sb.st_valid_o !== 1'b1 || sb.st_addr_o !== exp_addr[k]) begin
            failures++;
            $display("FAIL drain_order: handshake %0d st_valid=%b addr=%h required 1 addr=%h",
                     k, sb.st_valid_o, sb.st_addr_o, exp_addr[k]);
         end
         checks++;
         if (sb.full_o !== (k == 0)) begin
            failures++;
            $display("FAIL drain_full: handshake %0d full=%b required %b", k, sb.full_o, k == 0);
         end
         tick();
      end
      #2;
      checks++;
      if (sb.st_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL drain_stop: st_valid=%b required 0 at cptr", sb.st_valid_o);
      end
      drain_all();
   endtask

   task automatic test_forward();
      logic [31:0] ed;
      logic [3:0]  eb;
      logic        eok;
      drive_enq(30'h20, 32'hAAAA_1111, 4'b0011, 0, 5'd1);
      tick();
      drive_enq(30'h20, 32'hBB22_22BB, 4'b0110, 0, 5'd2);
      tick();
      drive_idle();
      sb.q_addr_i = 30'h20;
      sb.q_bm_i = 4'b0111;
      #2;
      m_fwd(30'h20, 4'b0111, ed, eb, eok);
      checks++;
      if (sb.fwd_data_o !== ed || sb.fwd_bm_o !== 4'b0111 || sb.fwd_ok_o !== 1'b1) begin
         failures++;
         $display("FAIL fwd_merge: data=%h bm=%b ok=%b required data=%h bm=0111 ok=1",
                  sb.fwd_data_o, sb.fwd_bm_o, sb.fwd_ok_o, ed);
      end
      sb.q_bm_i = 4'b1111;
      #1;
      checks++;
      if (sb.fwd_ok_o !== 1'b0 || sb.fwd_hit_o !== 1'b1 || sb.fwd_bm_o !== 4'b0111) begin
         failures++;
         $display("FAIL fwd_partial: ok=%b hit=%b bm=%b required ok=0 hit=1 bm=0111",
                  sb.fwd_ok_o, sb.fwd_hit_o, sb.fwd_bm_o);
      end
      sb.q_addr_i = 30'h21;
      #1;
      checks++;
      if (sb.fwd_hit_o !== 1'b0 || sb.fwd_data_o !== 32'h0) begin
         failures++;
         $display("FAIL fwd_miss: hit=%b data=%h required hit=0 data=0", sb.fwd_hit_o, sb.fwd_data_o);
      end
      drive_enq(30'h30, 32'h1234_5678, 4'b1111, 1, 5'd3);
      sb.q_addr_i = 30'h30;
      sb.q_bm_i = 4'b0001;
      #1;
      checks++;
      if (sb.fwd_hit_o !== 1'b0) begin
         failures++;
         $display("FAIL fwd_enq_invisible: hit=%b required 0", sb.fwd_hit_o);
      end
      tick();
      sb.enq_en_i = 0;
      #2;
      checks++;
      if (sb.fwd_hit_o !== 1'b1 || sb.fwd_ok_o !== 1'b0) begin
         failures++;
         $display("FAIL fwd_io: hit=%b ok=%b required hit=1 ok=0", sb.fwd_hit_o, sb.fwd_ok_o);
      end
      drain_all();
   endtask

   task automatic test_flush();
      for (int i = 0; i < 4; i++) begin
         drive_enq(30'h40 + 30'(i), $urandom, 4'hf, 0, 5'(10 + i));
         tick();
      end
      drive_enq(30'h44, 32'h5555_5555, 4'hf, 0, 5'd20);
      sb.flush_i = 1;
      sb.commit_i = 2'b01;
      #2;
      checks++;
      if (sb.cmp_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL flush_cmp_suppress: cmp_valid=%b required 0", sb.cmp_valid_o);
      end
      tick();
      drive_idle();
      sb.q_addr_i = 30'h41;
      sb.q_bm_i = 4'hf;
      #2;
      checks++;
      if (sb.cmp_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL flush_enq_dropped: cmp_valid=%b required 0", sb.cmp_valid_o);
      end
      checks++;
      if (sb.st_valid_o !== 1'b1 || sb.st_addr_o !== 30'h40 || sb.empty_o !== 1'b0) begin
         failures++;
         $display("FAIL flush_keep_committed: st_valid=%b addr=%h empty=%b required 1 40 0",
                  sb.st_valid_o, sb.st_addr_o, sb.empty_o);
      end
      checks++;
      if (sb.fwd_hit_o !== 1'b0) begin
         failures++;
         $display("FAIL flush_discard: hit=%b required 0 for flushed addr", sb.fwd_hit_o);
      end
      sb.st_done_i = 1;
      tick();
      sb.st_done_i = 0;
      #2;
      checks++;
      if (sb.empty_o !== 1'b1 || sb.st_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL flush_drained: empty=%b st_valid=%b required 1 0", sb.empty_o, sb.st_valid_o);
      end
   endtask

   task automatic test_reset_mid_drain();
      drive_enq(30'h70, 32'h7070_7070, 4'hf, 0, 5'd4);
      tick();
      drive_idle();
      sb.commit_i = 2'b01;
      tick();
      sb.commit_i = '0;
      sb.st_done_i = 1;
      #1;
      rst_n = 0;
      #1;
      checks++;
      if (sb.st_valid_o !== 1'b0 || sb.empty_o !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_drain: st_valid=%b empty=%b required 0 1", sb.st_valid_o, sb.empty_o);
      end
      m_reset();
      drive_idle();
      @(posedge clk);
      #2;
      rst_n = 1;
      @(posedge clk);
      #1;
   endtask

   // Cycle-by-cycle comparison of every output against the model; wrap mode streams 20 stores.
   task automatic test_traffic(input bit rnd, input int ncyc);
      logic [31:0] ed;
      logic [3:0]  eb;
      logic        eok;
      int          cyc = 0;
      while (cyc < ncyc && (rnd || cyc < 20 || mq.size() != 0)) begin
         drive_idle();
         if (rnd) begin
            if ($urandom_range(9) < 7)
               drive_enq(30'h60 + 30'($urandom_range(3)), $urandom, 4'($urandom), 1'($urandom_range(9) == 0), 5'($urandom));
            sb.commit_i = 2'($urandom);
            sb.st_done_i = 1'($urandom);
            sb.flush_i = ($urandom_range(19) == 0);
            sb.q_addr_i = 30'h60 + 30'($urandom_range(3));
            sb.q_bm_i = 4'($urandom);
         end else begin
            if (cyc < 20) drive_enq(30'h50 + 30'(cyc), $urandom, 4'hf, 0, 5'(cyc));
            sb.commit_i = 2'b01;
            sb.st_done_i = 1;
            sb.q_addr_i = 30'h50 + 30'(cyc % 20);
            sb.q_bm_i = 4'b1111;
         end
         #2;
         checks++;
         if ({sb.full_o, sb.empty_o, sb.st_valid_o} !== {mq.size() == DEPTH, mq.size() == 0, ncom > 0}) begin
            failures++;
            $display("FAIL traffic_flags: cyc %0d full/empty/st_valid=%b required %b", cyc,
                     {sb.full_o, sb.empty_o, sb.st_valid_o}, {mq.size() == DEPTH, mq.size() == 0, ncom > 0});
         end
         if (ncom > 0) begin
            checks++;
            if (sb.st_addr_o !== mq[0].addr || sb.st_data_o !== mq[0].data || sb.st_bm_o !== mq[0].bm) begin
               failures++;
               $display("FAIL traffic_store: cyc %0d addr=%h data=%h bm=%b required %h %h %b", cyc,
                        sb.st_addr_o, sb.st_data_o, sb.st_bm_o, mq[0].addr, mq[0].data, mq[0].bm);
            end
         end
         checks++;
         if (sb.cmp_valid_o !== (m_pend && !sb.flush_i) || (sb.cmp_valid_o === 1'b1 && sb.cmp_rob_o !== m_rob)) begin
            failures++;
            $display("FAIL traffic_cmp: cyc %0d cmp_valid=%b rob=%0d required %b rob=%0d", cyc,
                     sb.cmp_valid_o, sb.cmp_rob_o, m_pend && !sb.flush_i, m_rob);
         end
         m_fwd(sb.q_addr_i, sb.q_bm_i, ed, eb, eok);
         checks++;
         if (sb.fwd_data_o !== ed || sb.fwd_bm_o !== eb || sb.fwd_hit_o !== (eb != 0) || sb.fwd_ok_o !== eok) begin
            failures++;
            $display("FAIL traffic_fwd: cyc %0d data=%h bm=%b hit=%b ok=%b required %h %b %b %b", cyc,
                     sb.fwd_data_o, sb.fwd_bm_o, sb.fwd_hit_o, sb.fwd_ok_o, ed, eb, eb != 0, eok);
         end
         tick();
         cyc++;
      end
      if (!rnd) begin
         checks++;
         if (mq.size() != 0 || sb.empty_o !== 1'b1) begin
            failures++;
            $display("FAIL wrap_bound: empty=%b after %0d cycles required 1", sb.empty_o, cyc);
         end
      end
      drain_all();
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_forward();
      test_flush();
      test_reset_mid_drain();
      test_traffic(0, 200);
      test_traffic(1, 600);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
